nl_credit_link: RTL and testbench
=================================

Name: nl_credit_link

Overview:
- Parametrised inter-router link for the NL mesh.
- Successor to the fixed-latency flit-only pipelined channel: carries the forward flit path and the reverse credit path, each with configurable pipeline depth.
- Keeps per-VC sender-side credit counters, a saturating link-utilisation counter, and sticky protocol-error flags.
- Instantiated once per inter-router port, between a router output and the neighbour's input. Never used on the tile port.

Parameters:
FLIT_W, 64, flit payload width in bits (valid and VC carried separately)
NV, 2, number of virtual channels; VC fields are one-hot NV bits
STAGES, 1, register stages on each direction; 0 = combinational pass-through
CREDITS, 4, receiver buffer depth per VC = initial credit count
CNT_W, 32, utilisation counter width

Ports:
clk  in  1  link clock
rst_n  in  1  asynchronous active-low reset
up_valid  in  1  sender flit valid
up_data  in  FLIT_W  sender flit payload
up_vc  in  NV  sender flit VC, one-hot
up_credit_avail  out  NV  per-VC credit counter nonzero
dn_valid  out  1  flit valid at receiver
dn_data  out  FLIT_W  flit payload at receiver
dn_vc  out  NV  flit VC at receiver
dn_credit_valid  in  1  receiver freed one buffer slot
dn_credit_vc  in  NV  VC of freed slot, one-hot
util_clear  in  1  synchronous clear of util_count
err_clear  in  1  synchronous clear of error flags
util_count  out  CNT_W  cycles with dn_valid=1
drop_err  out  1  sticky: flit dropped
credit_ovf_err  out  1  sticky: credit returned to a full counter

Behaviour:
- Reset is asynchronous, on rst_n low:
  - All pipeline valid bits = 0.
  - Data and VC registers = 0.
  - Credit counters = CREDITS, so up_credit_avail = all ones.
  - util_count = 0, drop_err = 0, credit_ovf_err = 0.
- Reset asserted mid-transfer discards in-flight flits and credits. Counters return to CREDITS.
- Forward path:
  - The accepted flit (valid, data, vc) appears on dn_* exactly STAGES cycles later.
  - dn_valid=0 implies dn_data and dn_vc are don't-care, but they are driven registered values.
  - Only valid is reset-critical.
- Acceptance rule: the flit enters the pipeline iff up_valid=1, up_vc is one-hot, and the counter for that VC is > 0.
- Otherwise, with up_valid=1, the flit is dropped:
  - Its valid is not propagated.
  - drop_err is set on the next edge.
- Reverse path:
  - dn_credit_valid/dn_credit_vc pass through a STAGES-deep pipeline.
  - A credit with non-one-hot VC is ignored and sets drop_err.
- Credit counter per VC (width clog2(CREDITS+1)), per edge:
  - Accepted flit on VC v and emerging credit on v: no change.
  - Accepted flit only: decrement.
  - Emerging credit only: increment. If the counter already equals CREDITS, hold and set credit_ovf_err.
- up_credit_avail[v] = (counter[v] != 0), driven from registered state only; no combinational path from inputs.
- Credit round trip = 2*STAGES cycles plus receiver turnaround.
- util_count:
  - Increments on each edge where dn_valid=1.
  - Saturates at all-ones.
  - util_clear=1 loads 0 and takes priority over increment in the same cycle.
- Error flags:
  - Sticky until err_clear=1.
  - A set condition and err_clear in the same cycle: set wins.
- STAGES=0:
  - dn_* = accepted up_* combinationally; dn_valid is qualified by the acceptance rule.
  - Credit is applied the same cycle.
  - Counters and flags still registered.
- Simultaneous flit on VC a and credit on VC b≠a update both counters independently.

Test Plan:
1. Reset, STAGES=2, CREDITS=4 -> up_credit_avail=2'b11, dn_valid=0, util_count=0, flags 0; flit on VC0 at cycle 1 appears dn_valid=1, dn_vc=2'b01 at cycle 3, util_count=1 at cycle 4.
2. Send 4 flits on VC1 with no credits -> up_credit_avail[1]=0 after the 4th; 5th flit not delivered, drop_err=1; VC0 unaffected (still 4).
3. Counter for VC0 at 0, inject one dn_credit on VC0 while a flit is sent on VC1 -> after 2 cycles VC0 = 1, VC1 decremented by 1, no flags.
4. Counter at 3 on VC0, flit accepted on VC0 in the same edge as credit emerges on VC0 -> counter stays 3; return 2 extra credits with counter at 4 -> second sets credit_ovf_err, counter holds 4.
5. up_valid with up_vc=2'b11 -> no dn_valid, drop_err=1; err_clear alone -> 0; err_clear coinciding with a new drop -> stays 1.
6. Stream 10 flits back-to-back, assert util_clear on the cycle a flit emerges -> util_count=0 next cycle; pulse rst_n low mid-stream -> dn_valid=0 immediately (async), counters = 4.

Source files
------------

// File: rtl/nl_credit_link.sv
// NL mesh inter-router link: pipelined flit and credit paths,
// per-VC sender credit counters, utilisation counter and sticky errors.
module nl_credit_link #(
    parameter int FLIT_W  = 64,
    parameter int NV      = 2,
    parameter int STAGES  = 1,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    input  logic [FLIT_W-1:0] up_data,
    input  logic [NV-1:0]     up_vc,
    output logic [NV-1:0]     up_credit_avail,
    output logic              dn_valid,
    output logic [FLIT_W-1:0] dn_data,
    output logic [NV-1:0]     dn_vc,
    input  logic              dn_credit_valid,
    input  logic [NV-1:0]     dn_credit_vc,
    input  logic              util_clear,
    input  logic              err_clear,
    output logic [CNT_W-1:0]  util_count,
    output logic              drop_err,
    output logic              credit_ovf_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    function automatic logic onehot(input logic [NV-1:0] v);
        return (v != '0) && ((v & (v - NV'(1))) == '0);
    endfunction

    logic [NV-1:0] w_avail;
    logic          w_accept;
    logic          w_drop;
    logic          w_cr_v;
    logic [NV-1:0] w_cr_vc;
    logic          w_cr_ok;
    logic          w_cr_bad;
    logic [NV-1:0] w_ovf;

    logic [CNT_W-1:0] r_util;
    logic             r_drop_err;
    logic             r_ovf_err;

    // Acceptance only looks at registered credit state.
    assign w_accept = up_valid & onehot(up_vc) & ((up_vc & w_avail) != '0);
    assign w_drop   = up_valid & ~w_accept;

    generate
        if (STAGES == 0) begin : g_fwd_comb
            assign dn_valid = w_accept;
            assign dn_data  = up_data;
            assign dn_vc    = up_vc;
        end else begin : g_fwd_pipe
            logic              r_v [STAGES];
            logic [FLIT_W-1:0] r_d [STAGES];
            logic [NV-1:0]     r_c [STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_v[i] <= 1'b0;
                        r_d[i] <= '0;
                        r_c[i] <= '0;
                    end
                end else begin
                    r_v[0] <= w_accept;
                    r_d[0] <= up_data;
                    r_c[0] <= up_vc;
                    for (int i = 1; i < STAGES; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_d[i] <= r_d[i-1];
                        r_c[i] <= r_c[i-1];
                    end
                end
            end

            assign dn_valid = r_v[STAGES-1];
            assign dn_data  = r_d[STAGES-1];
            assign dn_vc    = r_c[STAGES-1];
        end
    endgenerate

    generate
        if (STAGES == 0) begin : g_crd_comb
            assign w_cr_v  = dn_credit_valid;
            assign w_cr_vc = dn_credit_vc;
        end else begin : g_crd_pipe
            logic          r_v [STAGES];
            logic [NV-1:0] r_c [STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        r_v[i] <= 1'b0;
                        r_c[i] <= '0;
                    end
                end else begin
                    r_v[0] <= dn_credit_valid;
                    r_c[0] <= dn_credit_vc;
                    for (int i = 1; i < STAGES; i++) begin
                        r_v[i] <= r_v[i-1];
                        r_c[i] <= r_c[i-1];
                    end
                end
            end

            assign w_cr_v  = r_v[STAGES-1];
            assign w_cr_vc = r_c[STAGES-1];
        end
    endgenerate

    assign w_cr_ok  = w_cr_v & onehot(w_cr_vc);
    assign w_cr_bad = w_cr_v & ~onehot(w_cr_vc);

    generate
        for (genvar v = 0; v < NV; v++) begin : g_vc
            logic [CW-1:0] r_cnt;
            logic          w_dec;
            logic          w_inc;
            logic          w_full;

            assign w_dec  = w_accept & up_vc[v];
            assign w_inc  = w_cr_ok & w_cr_vc[v];
            assign w_full = (r_cnt == CMAX);

            // Simultaneous consume and return cancel out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= CMAX;
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - CW'(1);
                end else if (w_inc && !w_dec && !w_full) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign w_ovf[v]   = w_inc & ~w_dec & w_full;
            assign w_avail[v] = (r_cnt != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_util <= '0;
        end else if (util_clear) begin
            r_util <= '0;
        end else if (dn_valid && (r_util != '1)) begin
            r_util <= r_util + CNT_W'(1);
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_err <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_drop_err <= (r_drop_err & ~err_clear) | w_drop | w_cr_bad;
            r_ovf_err  <= (r_ovf_err & ~err_clear) | (|w_ovf);
        end
    end

    assign up_credit_avail = w_avail;
    assign util_count      = r_util;
    assign drop_err        = r_drop_err;
    assign credit_ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_nl_credit_link.sv
// Directed bench for nl_credit_link with STAGES=2, CREDITS=4,
// NV=2 and a 4-bit utilisation counter so saturation is reachable.
module tb_nl_credit_link;

    localparam int FLIT_W = 64;
    localparam int NV     = 2;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              up_valid;
    logic [FLIT_W-1:0] up_data;
    logic [NV-1:0]     up_vc;
    logic [NV-1:0]     up_credit_avail;
    logic              dn_valid;
    logic [FLIT_W-1:0] dn_data;
    logic [NV-1:0]     dn_vc;
    logic              dn_credit_valid;
    logic [NV-1:0]     dn_credit_vc;
    logic              util_clear;
    logic              err_clear;
    logic [CNT_W-1:0]  util_count;
    logic              drop_err;
    logic              credit_ovf_err;

    int n_chk  = 0;
    int n_fail = 0;
    int seq    = 0;
    int n;

    nl_credit_link #(
        .FLIT_W (FLIT_W),
        .NV     (NV),
        .STAGES (2),
        .CREDITS(4),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .up_valid       (up_valid),
        .up_data        (up_data),
        .up_vc          (up_vc),
        .up_credit_avail(up_credit_avail),
        .dn_valid       (dn_valid),
        .dn_data        (dn_data),
        .dn_vc          (dn_vc),
        .dn_credit_valid(dn_credit_valid),
        .dn_credit_vc   (dn_credit_vc),
        .util_clear     (util_clear),
        .err_clear      (err_clear),
        .util_count     (util_count),
        .drop_err       (drop_err),
        .credit_ovf_err (credit_ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic send(input logic [NV-1:0] vc);
        up_valid = 1'b1;
        up_vc    = vc;
        up_data  = {32'hC0DE_0000, 32'(seq)};
        seq++;
        tick();
        up_valid = 1'b0;
        up_vc    = '0;
    endtask

    task automatic credit(input logic [NV-1:0] vc);
        dn_credit_valid = 1'b1;
        dn_credit_vc    = vc;
        tick();
        dn_credit_valid = 1'b0;
        dn_credit_vc    = '0;
    endtask

    task automatic clr_err();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    // Measures a VC counter by draining it, then returns the credits.
    task automatic count(input logic [NV-1:0] vc, output int c);
        c = 0;
        while (((up_credit_avail & vc) != '0) && c < 8) begin
            send(vc);
            c++;
        end
        idle(2);
        for (int i = 0; i < c; i++) credit(vc);
        idle(2);
    endtask

    initial begin
        rst_n           = 1'b0;
        up_valid        = 1'b0;
        up_data         = '0;
        up_vc           = '0;
        dn_credit_valid = 1'b0;
        dn_credit_vc    = '0;
        util_clear      = 1'b0;
        err_clear       = 1'b0;
        idle(3);
        chk("rst_avail", 64'(up_credit_avail), 64'h3);
        chk("rst_dn_valid", 64'(dn_valid), 64'h0);
        chk("rst_util", 64'(util_count), 64'h0);
        chk("rst_drop", 64'(drop_err), 64'h0);
        chk("rst_ovf", 64'(credit_ovf_err), 64'h0);
        rst_n = 1'b1;
        tick();

        // 1: two-stage forward latency
        up_valid = 1'b1;
        up_vc    = 2'b01;
        up_data  = 64'hA5A5_0000_0000_0001;
        tick();
        up_valid = 1'b0;
        up_vc    = '0;
        chk("t1_dn_early", 64'(dn_valid), 64'h0);
        tick();
        chk("t1_dn_valid", 64'(dn_valid), 64'h1);
        chk("t1_dn_vc", 64'(dn_vc), 64'h1);
        chk("t1_dn_data", dn_data, 64'hA5A5_0000_0000_0001);
        tick();
        chk("t1_util", 64'(util_count), 64'h1);
        chk("t1_dn_gone", 64'(dn_valid), 64'h0);
        credit(2'b01);
        idle(2);

        // 2: exhaust VC1, fifth flit dropped
        for (int i = 0; i < 4; i++) send(2'b10);
        chk("t2_avail", 64'(up_credit_avail), 64'h1);
        up_valid = 1'b1;
        up_vc    = 2'b10;
        tick();
        up_valid = 1'b0;
        up_vc    = '0;
        chk("t2_drop", 64'(drop_err), 64'h1);
        chk("t2_last_ok", 64'(dn_valid), 64'h1);
        tick();
        chk("t2_no_5th", 64'(dn_valid), 64'h0);
        count(2'b01, n);
        chk("t2_vc0_cnt", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) credit(2'b10);
        idle(2);
        clr_err();
        chk("t2_clr", 64'(drop_err), 64'h0);

        // 3: credit on VC0 while flit on VC1
        for (int i = 0; i < 4; i++) send(2'b01);
        chk("t3_vc0_empty", 64'(up_credit_avail), 64'h2);
        dn_credit_valid = 1'b1;
        dn_credit_vc    = 2'b01;
        up_valid        = 1'b1;
        up_vc           = 2'b10;
        tick();
        dn_credit_valid = 1'b0;
        dn_credit_vc    = '0;
        up_valid        = 1'b0;
        up_vc           = '0;
        idle(2);
        chk("t3_avail", 64'(up_credit_avail), 64'h3);
        count(2'b01, n);
        chk("t3_vc0_cnt", 64'(n), 64'd1);
        count(2'b10, n);
        chk("t3_vc1_cnt", 64'(n), 64'd3);
        chk("t3_drop", 64'(drop_err), 64'h0);
        chk("t3_ovf", 64'(credit_ovf_err), 64'h0);
        for (int i = 0; i < 3; i++) credit(2'b01);
        credit(2'b10);
        idle(2);

        // 4: flit and credit meet on VC0, then overflow
        send(2'b01);
        credit(2'b01);
        tick();
        send(2'b01);
        idle(2);
        count(2'b01, n);
        chk("t4_cnt_hold", 64'(n), 64'd3);
        credit(2'b01);
        idle(2);
        chk("t4_no_ovf", 64'(credit_ovf_err), 64'h0);
        credit(2'b01);
        idle(2);
        chk("t4_ovf", 64'(credit_ovf_err), 64'h1);
        count(2'b01, n);
        chk("t4_cnt_max", 64'(n), 64'd4);
        clr_err();
        chk("t4_ovf_clr", 64'(credit_ovf_err), 64'h0);

        // 5: non-one-hot VC and err_clear priority
        up_valid = 1'b1;
        up_vc    = 2'b11;
        tick();
        up_valid = 1'b0;
        up_vc    = '0;
        chk("t5_drop", 64'(drop_err), 64'h1);
        tick();
        chk("t5_no_dn", 64'(dn_valid), 64'h0);
        chk("t5_avail", 64'(up_credit_avail), 64'h3);
        clr_err();
        chk("t5_clr", 64'(drop_err), 64'h0);
        err_clear = 1'b1;
        up_valid  = 1'b1;
        up_vc     = 2'b00;
        tick();
        err_clear = 1'b0;
        up_valid  = 1'b0;
        chk("t5_set_wins", 64'(drop_err), 64'h1);
        clr_err();
        credit(2'b11);
        idle(2);
        chk("t5_bad_crd", 64'(drop_err), 64'h1);
        chk("t5_bad_no_ovf", 64'(credit_ovf_err), 64'h0);
        clr_err();

        // 6: streaming, util_clear, saturation, async reset
        util_clear = 1'b1;
        tick();
        util_clear = 1'b0;
        chk("t6_uclr", 64'(util_count), 64'h0);
        for (int i = 0; i < 10; i++) begin
            up_valid        = 1'b1;
            up_vc           = 2'b01;
            up_data         = 64'(i);
            dn_credit_valid = 1'b1;
            dn_credit_vc    = 2'b01;
            util_clear      = (i == 6);
            tick();
            if (i == 6) chk("t6_uclr_mid", 64'(util_count), 64'h0);
        end
        util_clear = 1'b0;
        chk("t6_util3", 64'(util_count), 64'h3);
        chk("t6_dn_live", 64'(dn_valid), 64'h1);
        chk("t6_no_drop", 64'(drop_err), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dn", 64'(dn_valid), 64'h0);
        chk("t6_rst_avail", 64'(up_credit_avail), 64'h3);
        chk("t6_rst_util", 64'(util_count), 64'h0);
        up_valid        = 1'b0;
        up_vc           = '0;
        dn_credit_valid = 1'b0;
        dn_credit_vc    = '0;
        tick();
        rst_n = 1'b1;
        tick();
        count(2'b01, n);
        chk("t6_cnt_rst", 64'(n), 64'd4);
        chk("t6_ovf_rst", 64'(credit_ovf_err), 64'h0);
        util_clear = 1'b1;
        tick();
        util_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            up_valid        = 1'b1;
            up_vc           = 2'b10;
            up_data         = 64'(i);
            dn_credit_valid = 1'b1;
            dn_credit_vc    = 2'b10;
            tick();
        end
        up_valid        = 1'b0;
        up_vc           = '0;
        dn_credit_valid = 1'b0;
        dn_credit_vc    = '0;
        idle(3);
        chk("t6_util_sat", 64'(util_count), 64'hF);
        chk("t6_sat_avail", 64'(up_credit_avail), 64'h3);
        chk("t6_sat_drop", 64'(drop_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
